// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce / edge-detect input stage.
// State encoding is Gray so each legal transition flips a single bit.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_CHKH = 2'b01,
    S_CHKL = 2'b10,
    S_HIGH = 2'b11
  } state_t;

  // Number of bits needed to hold values 0..value-1; 0 for value <= 1.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for asynchronous inputs; reusable for any width.
// All stages clear to zero on reset.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift register; stage 0 captures the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a raw asynchronous input and emits registered level, rise/fall
// pulses and a busy flag while a candidate level is being qualified.
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_raw,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int unsigned CNT_MIN_WIDTH = clog2(64'(STABLE_CYCLES) + 64'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Reject parameter sets that would break qualification or overflow the counter.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_edge_detect: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_edge_detect: STABLE_CYCLES must be >= 2");
  end
  if (CNT_WIDTH < CNT_MIN_WIDTH) begin : g_bad_cnt
    $error("debounce_edge_detect: CNT_WIDTH too narrow for STABLE_CYCLES");
  end

  logic                 sync_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_d, rise_d, fall_d, busy_d;

  sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_raw),
    .q     (sync_q)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOW;
      cnt_q      <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout       <= dout_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      busy       <= busy_d;
    end
  end

  // Next state; terminal compare precedes the increment so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q) begin
          state_d = S_CHKH;
          cnt_d   = CNT_ONE;
        end
      end
      S_CHKH: begin
        if (!sync_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          state_d = S_CHKL;
          cnt_d   = CNT_ONE;
        end
      end
      S_CHKL: begin
        if (sync_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output levels follow the next state so they register alongside it.
  always_comb begin
    dout_d = (state_d == S_HIGH) || (state_d == S_CHKL);
    busy_d = (state_d == S_CHKH) || (state_d == S_CHKL);
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect: a run-length reference model
// checked every cycle, plus literal expectations at key edges.
module tb_debounce_edge_detect;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned CNT_WIDTH     = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic din_raw;
  logic dout, rise_pulse, fall_pulse, busy;

  int checks = 0;
  int errors = 0;

  debounce_edge_detect #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_raw    (din_raw),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the level seen by the debouncer is the raw input delayed
  // by SYNC_STAGES samples; a new level is accepted after STABLE_CYCLES
  // consecutive samples that disagree with the current level.
  logic q_seen [$];
  logic m_dout, m_rise, m_fall;
  int   run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_seen.delete();
      for (int i = 0; i < int'(SYNC_STAGES); i++) q_seen.push_back(1'b0);
      m_dout = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      run    = 0;
    end else begin
      logic s;
      s = q_seen.pop_front();
      q_seen.push_back(din_raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      run = (s != m_dout) ? run + 1 : 0;
      if (run == int'(STABLE_CYCLES)) begin
        m_dout = s;
        m_rise = s;
        m_fall = ~s;
        run    = 0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_dout", dout, m_dout);
    check("model_rise", rise_pulse, m_rise);
    check("model_fall", fall_pulse, m_fall);
    check("model_busy", busy, logic'(run != 0));
    check("pulse_overlap", rise_pulse & fall_pulse, 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   rise_cnt;
  int   rise_edge;

  initial begin
    // 1. Reset with input high: everything stays low.
    rst_n   = 1'b0;
    din_raw = 1'b1;
    #1;
    check("rst_dout0", dout, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_dout", dout, 1'b0);
      check("rst_rise", rise_pulse, 1'b0);
      check("rst_fall", fall_pulse, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    din_raw = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("idle_dout", dout, 1'b0);
    check("idle_busy", busy, 1'b0);

    // 2. Clean press.
    din_raw = 1'b1;
    step(); check("press_e1_busy", busy, 1'b0);
    step(); check("press_e2_busy", busy, 1'b0);
    step(); check("press_e3_busy", busy, 1'b1);
            check("press_e3_dout", dout, 1'b0);
    step();
    step(); check("press_e5_dout", dout, 1'b0);
    step(); check("press_e6_dout", dout, 1'b1);
            check("press_e6_rise", rise_pulse, 1'b1);
            check("press_e6_busy", busy, 1'b0);
    step(); check("press_e7_rise", rise_pulse, 1'b0);
            check("press_e7_dout", dout, 1'b1);

    // 5. Release.
    din_raw = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      check("rel_dout_hold", dout, 1'b1);
      check("rel_fall_early", fall_pulse, 1'b0);
      if (n == 3) check("rel_e3_busy", busy, 1'b1);
    end
    step(); check("rel_e6_dout", dout, 1'b0);
            check("rel_e6_fall", fall_pulse, 1'b1);
    step(); check("rel_e7_fall", fall_pulse, 1'b0);
    for (int i = 0; i < 4; i++) step();

    // 3. Glitch one sample short of qualifying.
    din_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 4) din_raw = 1'b0;
      step();
      check("glitch_dout", dout, 1'b0);
      check("glitch_rise", rise_pulse, 1'b0);
    end
    check("glitch_busy", busy, 1'b0);

    // 4. Bounce then steady high: single rise after the last reversal.
    rise_cnt  = 0;
    rise_edge = 0;
    for (int n = 1; n <= 20; n++) begin
      din_raw = (n <= 6) ? pat[n-1] : 1'b1;
      step();
      if (rise_pulse) begin
        rise_cnt++;
        rise_edge = n;
      end
      if (n < 11) check("bounce_no_early", dout, 1'b0);
    end
    checks++;
    if (rise_cnt != 1) begin
      errors++;
      $display("FAIL bounce_rise_count: got %0d expected 1", rise_cnt);
    end
    checks++;
    if (rise_edge != 11) begin
      errors++;
      $display("FAIL bounce_rise_edge: got %0d expected 11", rise_edge);
    end
    check("bounce_dout", dout, 1'b1);

    // Back to low before the mid-qualification reset.
    din_raw = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pre6_dout", dout, 1'b0);

    // 6. Reset while qualifying a press with the counter at 2.
    din_raw = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout", dout, 1'b0);
    check("mid_rst_rise", rise_pulse, 1'b0);
    step();
    step();
    check("mid_hold_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      check("requal_dout_low", dout, 1'b0);
      check("requal_no_rise", rise_pulse, 1'b0);
    end
    step(); check("requal_e6_dout", dout, 1'b1);
            check("requal_e6_rise", rise_pulse, 1'b1);
    step(); check("requal_e7_rise", rise_pulse, 1'b0);

    // Asynchronous reset drops a high output mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_dout", dout, 1'b0);
    check("async_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
